reg_file_wordline: RTL and testbench

//  16-entry architectural register file sitting directly downstream of the 4-to-16 write decoder.

---
 rtl/reg_file_wordline_if.sv | 24 ++
 rtl/reg_file_wordline.sv | 72 +++++++
 tb/tb_reg_file_wordline.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_wordline_if.sv
// rtl/reg_file_wordline_if.sv - write wordline / read port bundle for the register file
interface reg_file_wordline_if #(
  parameter int DW = 16
);
  logic [15:0]   wordline;
  logic [DW-1:0] wr_data;
  logic [3:0]    src_reg1;
  logic [3:0]    src_reg2;
  logic [DW-1:0] src_data1;
  logic [DW-1:0] src_data2;
  logic          wl_err;

  // Driver side: decoder/writeback plus the decode stage issuing reads
  modport master (
    output wordline, wr_data, src_reg1, src_reg2,
    input  src_data1, src_data2, wl_err
  );

  // Register file side
  modport slave (
    input  wordline, wr_data, src_reg1, src_reg2,
    output src_data1, src_data2, wl_err
  );
endinterface

// File: rtl/reg_file_wordline.sv
// rtl/reg_file_wordline.sv - 16-entry register file with one-hot wordline write and bypassed reads
// Writes land only for a one-hot wordline; a multi-hot wordline writes nothing and
// raises a sticky error. Reads are combinational and forward same-cycle writeback data.
module reg_file_wordline #(
  parameter int DW      = 16,
  parameter int ZERO_R0 = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_file_wordline_if.slave    bus
);

  logic [DW-1:0] regs [16];
  logic          wl_nonzero;
  logic          wl_one_hot;
  logic          wl_multi_hot;
  logic          wl_err_q;

  // Classify the wordline: a single set bit means the decoder produced a legal write
  always_comb begin
    wl_nonzero   = (bus.wordline != 16'h0000);
    wl_one_hot   = wl_nonzero && ((bus.wordline & (bus.wordline - 16'd1)) == 16'h0000);
    wl_multi_hot = wl_nonzero && !wl_one_hot;
  end

  // Register storage: reset clears everything and beats any write in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (wl_one_hot && bus.wordline[i] && !((ZERO_R0 != 0) && (i == 0))) begin
          regs[i] <= bus.wr_data;
        end
      end
    end
  end

  // Sticky malformed-wordline flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wl_err_q <= 1'b0;
    end else if (wl_multi_hot) begin
      wl_err_q <= 1'b1;
    end
  end

  // Read port 1: hardwired zero, then bypass of a legal same-cycle write, then storage
  always_comb begin
    bus.src_data1 = regs[bus.src_reg1];
    if ((ZERO_R0 != 0) && (bus.src_reg1 == 4'd0)) begin
      bus.src_data1 = '0;
    end else if (wl_one_hot && bus.wordline[bus.src_reg1]) begin
      bus.src_data1 = bus.wr_data;
    end
  end

  // Read port 2: same selection as port 1, fully independent
  always_comb begin
    bus.src_data2 = regs[bus.src_reg2];
    if ((ZERO_R0 != 0) && (bus.src_reg2 == 4'd0)) begin
      bus.src_data2 = '0;
    end else if (wl_one_hot && bus.wordline[bus.src_reg2]) begin
      bus.src_data2 = bus.wr_data;
    end
  end

  assign bus.wl_err = wl_err_q;

endmodule

// File: tb/tb_reg_file_wordline.sv
// tb/tb_reg_file_wordline.sv - directed self-checking bench for reg_file_wordline
module tb_reg_file_wordline;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  reg_file_wordline_if #(.DW(16)) bus ();

  reg_file_wordline #(.DW(16), .ZERO_R0(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then let inputs change away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [3:0] id, input logic [15:0] data);
    bus.wordline = 16'h0001 << id;
    bus.wr_data  = data;
    step();
    bus.wordline = 16'h0000;
    #1;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.wordline = 16'h0008;
    bus.wr_data  = 16'hFFFF;
    step();
    step();
    bus.wordline = 16'h0000;
    rst          = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.src_reg1 = i[3:0];
      bus.src_reg2 = 4'(15 - i);
      #1;
      n_cmp++;
      if (bus.src_data1 !== 16'h0000) begin
        n_err++;
        $display("FAIL reset_rd1 id=%0d got=%h exp=0000", i, bus.src_data1);
      end
      n_cmp++;
      if (bus.src_data2 !== 16'h0000) begin
        n_err++;
        $display("FAIL reset_rd2 id=%0d got=%h exp=0000", 15 - i, bus.src_data2);
      end
    end
    n_cmp++;
    if (bus.wl_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_wl_err got=%b exp=0", bus.wl_err);
    end
  endtask

  task automatic test_write_read();
    write_reg(4'd3, 16'hBEEF);
    bus.src_reg1 = 4'd3;
    bus.src_reg2 = 4'd4;
    #1;
    n_cmp++;
    if (bus.src_data1 !== 16'hBEEF) begin
      n_err++;
      $display("FAIL wr_rd_r3 got=%h exp=BEEF", bus.src_data1);
    end
    n_cmp++;
    if (bus.src_data2 !== 16'h0000) begin
      n_err++;
      $display("FAIL wr_rd_r4 got=%h exp=0000", bus.src_data2);
    end
  endtask

  task automatic test_bypass();
    write_reg(4'd5, 16'h1111);
    bus.src_reg1 = 4'd5;
    bus.src_reg2 = 4'd5;
    #1;
    n_cmp++;
    if (bus.src_data1 !== 16'h1111) begin
      n_err++;
      $display("FAIL byp_stored got=%h exp=1111", bus.src_data1);
    end
    bus.wordline = 16'h0020;
    bus.wr_data  = 16'h2222;
    #1;
    n_cmp++;
    if (bus.src_data1 !== 16'h2222) begin
      n_err++;
      $display("FAIL byp_rd1 got=%h exp=2222", bus.src_data1);
    end
    n_cmp++;
    if (bus.src_data2 !== 16'h2222) begin
      n_err++;
      $display("FAIL byp_rd2 got=%h exp=2222", bus.src_data2);
    end
    step();
    bus.wordline = 16'h0000;
    bus.wr_data  = 16'h0000;
    #1;
    n_cmp++;
    if (bus.src_data1 !== 16'h2222) begin
      n_err++;
      $display("FAIL byp_after got=%h exp=2222", bus.src_data1);
    end
  endtask

  task automatic test_r0();
    bus.wordline = 16'h0001;
    bus.wr_data  = 16'h1234;
    bus.src_reg1 = 4'd0;
    bus.src_reg2 = 4'd0;
    #1;
    n_cmp++;
    if (bus.src_data1 !== 16'h0000) begin
      n_err++;
      $display("FAIL r0_during got=%h exp=0000", bus.src_data1);
    end
    n_cmp++;
    if (bus.src_data2 !== 16'h0000) begin
      n_err++;
      $display("FAIL r0_during_p2 got=%h exp=0000", bus.src_data2);
    end
    step();
    bus.wordline = 16'h0000;
    #1;
    n_cmp++;
    if (bus.src_data1 !== 16'h0000) begin
      n_err++;
      $display("FAIL r0_after got=%h exp=0000", bus.src_data1);
    end
  endtask

  task automatic test_multi_hot();
    write_reg(4'd1, 16'hAAAA);
    write_reg(4'd2, 16'h5555);
    bus.wordline = 16'h0006;
    bus.wr_data  = 16'h0F0F;
    bus.src_reg1 = 4'd1;
    bus.src_reg2 = 4'd2;
    #1;
    n_cmp++;
    if (bus.src_data1 !== 16'hAAAA) begin
      n_err++;
      $display("FAIL mh_nobyp1 got=%h exp=AAAA", bus.src_data1);
    end
    n_cmp++;
    if (bus.src_data2 !== 16'h5555) begin
      n_err++;
      $display("FAIL mh_nobyp2 got=%h exp=5555", bus.src_data2);
    end
    n_cmp++;
    if (bus.wl_err !== 1'b0) begin
      n_err++;
      $display("FAIL mh_err_before got=%b exp=0", bus.wl_err);
    end
    step();
    bus.wordline = 16'h0000;
    #1;
    n_cmp++;
    if (bus.src_data1 !== 16'hAAAA) begin
      n_err++;
      $display("FAIL mh_r1_kept got=%h exp=AAAA", bus.src_data1);
    end
    n_cmp++;
    if (bus.src_data2 !== 16'h5555) begin
      n_err++;
      $display("FAIL mh_r2_kept got=%h exp=5555", bus.src_data2);
    end
    n_cmp++;
    if (bus.wl_err !== 1'b1) begin
      n_err++;
      $display("FAIL mh_err_set got=%b exp=1", bus.wl_err);
    end
    write_reg(4'd4, 16'h4444);
    bus.src_reg1 = 4'd4;
    #1;
    n_cmp++;
    if (bus.src_data1 !== 16'h4444) begin
      n_err++;
      $display("FAIL mh_later_write got=%h exp=4444", bus.src_data1);
    end
    n_cmp++;
    if (bus.wl_err !== 1'b1) begin
      n_err++;
      $display("FAIL mh_err_sticky got=%b exp=1", bus.wl_err);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.wl_err !== 1'b0) begin
      n_err++;
      $display("FAIL mh_err_cleared got=%b exp=0", bus.wl_err);
    end
    n_cmp++;
    if (bus.src_data1 !== 16'h0000) begin
      n_err++;
      $display("FAIL mh_r4_cleared got=%h exp=0000", bus.src_data1);
    end
  endtask

  task automatic test_reset_mid_write();
    rst          = 1'b1;
    bus.wordline = 16'h8000;
    bus.wr_data  = 16'h7777;
    bus.src_reg1 = 4'd15;
    #1;
    n_cmp++;
    if (bus.src_data1 !== 16'h7777) begin
      n_err++;
      $display("FAIL rmw_bypass_in_reset got=%h exp=7777", bus.src_data1);
    end
    step();
    bus.wordline = 16'h0000;
    #1;
    n_cmp++;
    if (bus.src_data1 !== 16'h0000) begin
      n_err++;
      $display("FAIL rmw_lost got=%h exp=0000", bus.src_data1);
    end
    rst          = 1'b0;
    bus.wordline = 16'h8000;
    step();
    bus.wordline = 16'h0000;
    #1;
    n_cmp++;
    if (bus.src_data1 !== 16'h7777) begin
      n_err++;
      $display("FAIL rmw_rewrite got=%h exp=7777", bus.src_data1);
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst          = 1'b1;
    bus.wordline = 16'h0000;
    bus.wr_data  = 16'h0000;
    bus.src_reg1 = 4'd0;
    bus.src_reg2 = 4'd0;
    test_reset();
    test_write_read();
    test_bypass();
    test_r0();
    test_multi_hot();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
